// File: rtl/pipe_core.sv
// rtl/pipe_core.sv - four-stage ID/EX/MEM/WB load/store core with forwarding and memory handshake
// Define MUL_EN to build the multiplier; otherwise MUL writes zero.
module pipe_core #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [2:0]              op_code,
    input  logic [$clog2(NREG)-1:0] op_rs,
    input  logic [$clog2(NREG)-1:0] op_rt,
    input  logic [$clog2(NREG)-1:0] op_rd,
    input  logic [15:0]             op_imm,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    wb_valid,
    output logic [$clog2(NREG)-1:0] wb_addr,
    output logic [DATA_W-1:0]       wb_data
);
    localparam int RW = $clog2(NREG);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4, OP_LD = 3'd5, OP_ST = 3'd6, OP_LI = 3'd7;

    logic [DATA_W-1:0] rf [NREG];

    logic              ex_valid, mem_valid, wbs_valid;
    logic [2:0]        ex_op, mem_op;
    logic [RW-1:0]     ex_rd, mem_rd, wbs_rd;
    logic [DATA_W-1:0] ex_a, ex_b, ex_imm, mem_res, mem_b, wbs_data;

    logic [DATA_W-1:0] id_a, id_b, ex_res, mem_out;
    logic              ex_wr, mem_wr, wbs_wr, mem_acc, mem_stall, ld_hazard, accept;

    assign ex_wr   = ex_valid && ex_op != OP_ST && ex_rd != '0;
    assign mem_wr  = mem_valid && mem_op != OP_ST && mem_rd != '0;
    assign wbs_wr  = wbs_valid && wbs_rd != '0;
    assign mem_out = (mem_op == OP_LD) ? mem_rdata : mem_res;

    assign mem_acc   = mem_valid && (mem_op == OP_LD || mem_op == OP_ST);
    assign mem_stall = mem_acc && !mem_ack;
    assign ld_hazard = op_valid && ex_valid && ex_op == OP_LD && ex_rd != '0 &&
                       (ex_rd == op_rs || ex_rd == op_rt);
    assign op_ready  = rst && !mem_stall && !ld_hazard;
    assign accept    = op_valid && op_ready;

    assign mem_req   = mem_acc;
    assign mem_we    = mem_valid && mem_op == OP_ST;
    assign mem_addr  = mem_res[ADDR_W-1:0];
    assign mem_wdata = mem_b;

    // Operand select, youngest producer wins; r0 always reads as zero.
    always_comb begin
        id_a = '0;
        if (op_rs != '0) begin
            if (ex_wr && ex_rd == op_rs)        id_a = ex_res;
            else if (mem_wr && mem_rd == op_rs) id_a = mem_out;
            else if (wbs_wr && wbs_rd == op_rs) id_a = wbs_data;
            else                                id_a = rf[op_rs];
        end
    end

    always_comb begin
        id_b = '0;
        if (op_rt != '0) begin
            if (ex_wr && ex_rd == op_rt)        id_b = ex_res;
            else if (mem_wr && mem_rd == op_rt) id_b = mem_out;
            else if (wbs_wr && wbs_rd == op_rt) id_b = wbs_data;
            else                                id_b = rf[op_rt];
        end
    end

    always_comb begin
        ex_res = '0;
        case (ex_op)
            OP_ADD:        ex_res = ex_a + ex_b;
            OP_SUB:        ex_res = ex_a - ex_b;
            OP_AND:        ex_res = ex_a & ex_b;
            OP_OR:         ex_res = ex_a | ex_b;
`ifdef MUL_EN
            OP_MUL:        ex_res = ex_a * ex_b;
`else
            OP_MUL:        ex_res = '0;
`endif
            OP_LD, OP_ST:  ex_res = ex_a + ex_imm;
            OP_LI:         ex_res = ex_imm;
            default:       ex_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_op     <= '0;
            ex_rd     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            mem_valid <= 1'b0;
            mem_op    <= '0;
            mem_rd    <= '0;
            mem_res   <= '0;
            mem_b     <= '0;
            wbs_valid <= 1'b0;
            wbs_rd    <= '0;
            wbs_data  <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            // A pending memory access freezes ID/EX/MEM; WB keeps draining.
            if (!mem_stall) begin
                ex_valid <= accept;
                if (accept) begin
                    ex_op  <= op_code;
                    ex_rd  <= op_rd;
                    ex_a   <= id_a;
                    ex_b   <= id_b;
                    ex_imm <= {{(DATA_W-16){op_imm[15]}}, op_imm};
                end
                mem_valid <= ex_valid;
                mem_op    <= ex_op;
                mem_rd    <= ex_rd;
                mem_res   <= ex_res;
                mem_b     <= ex_b;
                wbs_valid <= mem_valid && mem_op != OP_ST;
                wbs_rd    <= mem_rd;
                wbs_data  <= mem_out;
            end else begin
                wbs_valid <= 1'b0;
            end
            wb_valid <= wbs_wr;
            if (wbs_wr) begin
                wb_addr     <= wbs_rd;
                wb_data     <= wbs_data;
                rf[wbs_rd]  <= wbs_data;
            end
        end
    end
endmodule

// File: tb/tb_pipe_core.sv
// tb/tb_pipe_core.sv - table-driven scoreboard bench for pipe_core
module tb_pipe_core;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4, OP_LD = 3'd5, OP_ST = 3'd6, OP_LI = 3'd7;
`ifdef MUL_EN
    localparam logic [31:0] MUL_EXP = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] MUL_EXP = 32'h0;
`endif
    localparam int NV = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = '0;
    logic [4:0]  op_rs = '0, op_rt = '0, op_rd = '0;
    logic [15:0] op_imm = '0;
    logic        op_ready, mem_req, mem_we, wb_valid;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, wb_data;
    logic [31:0] mem_rdata_r = '0;
    logic [4:0]  wb_addr;
    logic        ack_r = 1'b0, stray_ack = 1'b0, mem_ack_w;

    assign mem_ack_w = ack_r | stray_ack;

    pipe_core #(.DATA_W(32), .NREG(32), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rs(op_rs), .op_rt(op_rt), .op_rd(op_rd), .op_imm(op_imm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_r),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  code;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        bit          wb;
        logic [31:0] data;
        int          lat;
        logic [9:0]  maddr;
        logic [31:0] mwdata;
        int          wt;
    } vec_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; int lat; int acc; } wb_t;
    typedef struct { bit we; logic [9:0] addr; logic [31:0] wdata; int wt; } mr_t;

    wb_t  wbq[$];
    mr_t  mrq[$];
    wb_t  mon_e;
    vec_t tbl [NV];
    int   acc [NV];
    int   n_cmp = 0, n_bad = 0, cyc = 0, bad_ready = 0, unstable = 0;
    logic [31:0] tb_mem [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: checks each new request, acks after the queued wait count.
    initial begin : responder
        bit  in_req;
        int  waitc, nreq;
        mr_t cur;
        in_req = 0; waitc = 0; nreq = 0;
        cur = '{1'b0, 10'd0, 32'd0, 0};
        for (int i = 0; i < 1024; i++) tb_mem[i] = '0;
        forever begin
            @(posedge clk); #1;
            ack_r = 1'b0;
            if (mem_req) begin
                if (!in_req) begin
                    in_req = 1; waitc = 0; nreq = 0;
                    if (mrq.size() == 0) begin
                        check("mem_req_spurious", 64'(mem_req), 64'd0);
                        cur = '{mem_we, mem_addr, mem_wdata, 0};
                    end else begin
                        cur = mrq.pop_front();
                        check("mem_we", 64'(mem_we), 64'(cur.we));
                        check("mem_addr", 64'(mem_addr), 64'(cur.addr));
                        if (cur.we) check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    end
                end else if (mem_addr != cur.addr || (cur.we && mem_wdata != cur.wdata)) begin
                    unstable++;
                end
                nreq++;
                if (waitc == cur.wt) begin
                    ack_r = 1'b1;
                    if (mem_we) tb_mem[mem_addr] = mem_wdata;
                    else        mem_rdata_r = tb_mem[mem_addr];
                    check("mem_req_cycles", 64'(nreq), 64'(cur.wt + 1));
                    in_req = 0;
                end else begin
                    waitc++;
                end
            end else begin
                in_req = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && mem_req && !mem_ack_w && op_ready) bad_ready++;
        if (wb_valid) begin
            if (wbq.size() == 0) begin
                check("wb_spurious", 64'(wb_valid), 64'd0);
            end else begin
                mon_e = wbq.pop_front();
                check("wb_addr", 64'(wb_addr), 64'(mon_e.rd));
                check("wb_data", 64'(wb_data), 64'(mon_e.data));
                if (mon_e.lat >= 0) check("wb_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    task automatic issue(input vec_t v, output int a);
        int tries;
        tries = 0;
        op_code = v.code; op_rs = v.rs; op_rt = v.rt; op_rd = v.rd; op_imm = v.imm;
        op_valid = 1'b1;
        @(negedge clk);
        while (!op_ready && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (!op_ready) begin
            check("issue_timeout", 64'(op_ready), 64'd1);
            op_valid = 1'b0;
            a = -1;
            return;
        end
        a = cyc + 1;
        if (v.wb) wbq.push_back('{v.rd, v.data, v.lat, a});
        if (v.code == OP_LD || v.code == OP_ST) mrq.push_back('{v.code == OP_ST, v.maddr, v.mwdata, v.wt});
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((wbq.size() != 0 || mrq.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
        check(name, 64'(wbq.size() + mrq.size()), 64'd0);
    endtask

    initial begin
        int a;
        int t;
        //           code    rs    rt    rd    imm        wb  data            lat maddr   mwdata  wt
        tbl[0]  = '{OP_LI,  5'd0, 5'd0, 5'd1, 16'd5,     1, 32'd5,          3, 10'd0,  32'd0,  0};
        tbl[1]  = '{OP_LI,  5'd0, 5'd0, 5'd2, 16'd7,     1, 32'd7,          3, 10'd0,  32'd0,  0};
        tbl[2]  = '{OP_ADD, 5'd1, 5'd2, 5'd3, 16'd0,     1, 32'd12,         3, 10'd0,  32'd0,  0};
        tbl[3]  = '{OP_ST,  5'd0, 5'd3, 5'd0, 16'd4,     0, 32'd0,         -1, 10'd4,  32'd12, 3};
        tbl[4]  = '{OP_OR,  5'd3, 5'd0, 5'd16, 16'd0,    1, 32'd12,        -1, 10'd0,  32'd0,  0};
        tbl[5]  = '{OP_LD,  5'd0, 5'd0, 5'd4, 16'd4,     1, 32'd12,        -1, 10'd4,  32'd0,  0};
        tbl[6]  = '{OP_ADD, 5'd4, 5'd4, 5'd5, 16'd0,     1, 32'd24,         3, 10'd0,  32'd0,  0};
        tbl[7]  = '{OP_LI,  5'd0, 5'd0, 5'd0, 16'd9,     0, 32'd0,         -1, 10'd0,  32'd0,  0};
        tbl[8]  = '{OP_ADD, 5'd0, 5'd0, 5'd6, 16'd0,     1, 32'd0,          3, 10'd0,  32'd0,  0};
        tbl[9]  = '{OP_LI,  5'd0, 5'd0, 5'd1, 16'hFFFF,  1, 32'hFFFF_FFFF,  3, 10'd0,  32'd0,  0};
        tbl[10] = '{OP_LI,  5'd0, 5'd0, 5'd2, 16'd2,     1, 32'd2,          3, 10'd0,  32'd0,  0};
        tbl[11] = '{OP_MUL, 5'd1, 5'd2, 5'd7, 16'd0,     1, MUL_EXP,        3, 10'd0,  32'd0,  0};
        tbl[12] = '{OP_SUB, 5'd2, 5'd1, 5'd8, 16'd0,     1, 32'd3,          3, 10'd0,  32'd0,  0};
        tbl[13] = '{OP_AND, 5'd1, 5'd3, 5'd9, 16'd0,     1, 32'd12,         3, 10'd0,  32'd0,  0};
        tbl[14] = '{OP_OR,  5'd2, 5'd3, 5'd10, 16'd0,    1, 32'd14,         3, 10'd0,  32'd0,  0};
        tbl[15] = '{OP_ADD, 5'd8, 5'd9, 5'd11, 16'd0,    1, 32'd15,         3, 10'd0,  32'd0,  0};
        tbl[16] = '{OP_LD,  5'd11, 5'd0, 5'd12, 16'hFFF5, 1, 32'd12,       -1, 10'd4,  32'd0,  2};
        tbl[17] = '{OP_ST,  5'd0, 5'd12, 5'd0, 16'h03FF, 0, 32'd0,         -1, 10'h3FF, 32'd12, 1};
        tbl[18] = '{OP_LD,  5'd0, 5'd0, 5'd13, 16'h03FF, 1, 32'd12,        -1, 10'h3FF, 32'd0,  0};
        tbl[19] = '{OP_ADD, 5'd13, 5'd5, 5'd14, 16'd0,   1, 32'd36,        -1, 10'd0,  32'd0,  0};
        tbl[20] = '{OP_SUB, 5'd0, 5'd14, 5'd15, 16'd0,   1, 32'hFFFF_FFDC, -1, 10'd0,  32'd0,  0};
        tbl[21] = '{OP_LI,  5'd0, 5'd0, 5'd17, 16'h8000, 1, 32'hFFFF_8000, -1, 10'd0,  32'd0,  0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(op_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) issue(tbl[i], acc[i]);
        check("li_li_gap", 64'(acc[1] - acc[0]), 64'd1);
        check("li_add_gap", 64'(acc[2] - acc[1]), 64'd1);
        check("load_use_gap", 64'(acc[6] - acc[5]), 64'd2);
        check("r0_gap", 64'(acc[8] - acc[7]), 64'd1);
        drain("table_drained");

        // Reset while a load is waiting, then a stray ack.
        issue('{OP_LD, 5'd0, 5'd0, 5'd20, 16'd8, 1, 32'd0, -1, 10'd8, 32'd0, 1000}, a);
        t = 0;
        while (!mem_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("abort_req_seen", 64'(mem_req), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready_in_reset", 64'(op_ready), 64'd0);
        check("abort_mem_req", 64'(mem_req), 64'd0);
        wbq.delete();
        mrq.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_after", 64'(op_ready), 64'd1);
        @(posedge clk); #1;
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_ignored", 64'(mem_req), 64'd0);
        repeat (6) @(posedge clk);
        #1;

        issue('{OP_LI,  5'd0, 5'd0, 5'd1, 16'd3, 1, 32'd3, 3, 10'd0, 32'd0, 0}, a);
        issue('{OP_ADD, 5'd1, 5'd1, 5'd2, 16'd0, 1, 32'd6, 3, 10'd0, 32'd0, 0}, a);
        issue('{OP_ADD, 5'd5, 5'd1, 5'd3, 16'd0, 1, 32'd3, 3, 10'd0, 32'd0, 0}, a);
        issue('{OP_ADD, 5'd14, 5'd0, 5'd4, 16'd0, 1, 32'd0, 3, 10'd0, 32'd0, 0}, a);
        drain("post_reset_drained");

        check("ready_low_during_wait", 64'(bad_ready), 64'd0);
        check("mem_req_stable", 64'(unstable), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
